// File: rtl/axi_bfm_pkg.sv
// ============================================================================
// Module      : axi_bfm_pkg
// Description : Shared constants, write-FSM encodings and helpers for the AXI4 master BFM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_bfm_pkg;

    localparam logic [1:0] c_BURST_INCR = 2'b01;
    localparam logic [3:0] c_CACHE      = 4'b0011;
    localparam logic [1:0] c_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    // Ceiling log2, evaluated at elaboration for AxSIZE.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_bfm_wr_ctrl.sv
// ============================================================================
// Module      : axi_bfm_wr_ctrl
// Description : Write-side FSM of the AXI4 master BFM: AW issue, W beat counting, B collection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_bfm_wr_ctrl
    import axi_bfm_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_accept,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [7:0]            i_cmd_len,
    input  logic [ID_WIDTH-1:0]   i_cmd_id,
    output logic                  o_idle,
    input  logic [DATA_WIDTH-1:0] i_usr_wdata,
    input  logic [MASK_WIDTH-1:0] i_usr_wstrb,
    input  logic                  i_usr_wvalid,
    output logic                  o_usr_wready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [ID_WIDTH-1:0]   o_awid,
    output logic [7:0]            o_awlen,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [MASK_WIDTH-1:0] o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [ID_WIDTH-1:0]   i_bid,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    output logic                  o_wr_done,
    output logic [ID_WIDTH-1:0]   o_wr_done_id
);

    wr_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [7:0]            r_len;
    logic                  r_awvalid;
    logic [7:0]            r_beat_cnt;
    logic                  r_bready;
    logic                  r_wr_done;
    logic [ID_WIDTH-1:0]   r_wr_done_id;

    logic w_in_data;
    logic w_wvalid;
    logic w_wlast;
    logic w_beat;

    // W traffic is only exposed once the address phase has completed.
    assign w_in_data = (r_state == W_DATA);
    assign w_wvalid  = w_in_data && i_usr_wvalid;
    assign w_wlast   = w_in_data && (r_beat_cnt == r_len);
    assign w_beat    = w_wvalid && i_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= W_IDLE;
            r_awaddr     <= '0;
            r_awid       <= '0;
            r_len        <= '0;
            r_awvalid    <= 1'b0;
            r_beat_cnt   <= '0;
            r_bready     <= 1'b0;
            r_wr_done    <= 1'b0;
            r_wr_done_id <= '0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                W_IDLE: begin
                    if (i_cmd_accept) begin
                        r_awaddr  <= i_cmd_addr;
                        r_awid    <= i_cmd_id;
                        r_len     <= i_cmd_len;
                        r_awvalid <= 1'b1;
                        r_state   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (i_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        if (w_wlast) begin
                            r_beat_cnt <= '0;
                            r_bready   <= 1'b1;
                            r_state    <= W_RESP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (i_bvalid) begin
                        r_bready     <= 1'b0;
                        r_wr_done    <= 1'b1;
                        r_wr_done_id <= i_bid;
                        r_state      <= W_IDLE;
                    end
                end
                default: r_state <= W_IDLE;
            endcase
        end
    end

    assign o_idle       = (r_state == W_IDLE);
    assign o_usr_wready = w_in_data && i_wready;
    assign o_awaddr     = r_awaddr;
    assign o_awid       = r_awid;
    assign o_awlen      = r_len;
    assign o_awvalid    = r_awvalid;
    assign o_wdata      = i_usr_wdata;
    assign o_wstrb      = i_usr_wstrb;
    assign o_wlast      = w_wlast;
    assign o_wvalid     = w_wvalid;
    assign o_bready     = r_bready;
    assign o_wr_done    = r_wr_done;
    assign o_wr_done_id = r_wr_done_id;

endmodule

`default_nettype wire

// File: rtl/axi_master_bfm.sv
// ============================================================================
// Module      : axi_master_bfm
// Description : AXI4 master BFM turning simple user commands and streams into AW/W/B/AR/R traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_master_bfm
    import axi_bfm_pkg::*;
#(
    parameter int DATA_WIDTH         = 512,
    parameter int ADDR_WIDTH         = 64,
    parameter int MASK_WIDTH         = DATA_WIDTH / 8,
    parameter int ID_WIDTH           = 4,
    parameter int MAX_RD_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DATA_WIDTH-1:0] usr_wdata,
    input  logic [MASK_WIDTH-1:0] usr_wstrb,
    input  logic                  usr_wvalid,
    output logic                  usr_wready,
    output logic [DATA_WIDTH-1:0] usr_rdata,
    output logic [ID_WIDTH-1:0]   usr_rid,
    output logic                  usr_rlast,
    output logic                  usr_rvalid,
    input  logic                  usr_rready,
    output logic                  wr_done,
    output logic [ID_WIDTH-1:0]   wr_done_id,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [ID_WIDTH-1:0]   awid,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [3:0]            awcache,
    output logic                  awlock,
    output logic [2:0]            awprot,
    output logic [3:0]            awqos,
    output logic [3:0]            awregion,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [MASK_WIDTH-1:0] wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [3:0]            arcache,
    output logic                  arlock,
    output logic [2:0]            arprot,
    output logic [3:0]            arqos,
    output logic [3:0]            arregion,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [2:0] c_AXSIZE    = 3'(log2(MASK_WIDTH));
    localparam logic [7:0] c_MAX_OUTST = 8'(MAX_RD_OUTSTANDING);

    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [7:0]            r_arlen;
    logic [7:0]            r_rd_outst;
    logic [15:0]           r_err_cnt;

    logic        w_wr_idle;
    logic        w_cmd_ready;
    logic        w_rd_accept;
    logic        w_wr_accept;
    logic        w_rd_done;
    logic        w_b_err;
    logic        w_r_err;
    logic [16:0] w_err_sum;

    always_comb begin
        w_cmd_ready = w_wr_idle;
        if (cmd_rnw) begin
            w_cmd_ready = !r_arvalid && (r_rd_outst < c_MAX_OUTST);
        end
    end

    assign w_rd_accept = cmd_valid && w_cmd_ready && cmd_rnw;
    assign w_wr_accept = cmd_valid && w_cmd_ready && !cmd_rnw;
    assign w_rd_done   = rvalid && usr_rready && rlast;

    axi_bfm_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MASK_WIDTH (MASK_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_wr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_accept (w_wr_accept),
        .i_cmd_addr   (cmd_addr),
        .i_cmd_len    (cmd_len),
        .i_cmd_id     (cmd_id),
        .o_idle       (w_wr_idle),
        .i_usr_wdata  (usr_wdata),
        .i_usr_wstrb  (usr_wstrb),
        .i_usr_wvalid (usr_wvalid),
        .o_usr_wready (usr_wready),
        .o_awaddr     (awaddr),
        .o_awid       (awid),
        .o_awlen      (awlen),
        .o_awvalid    (awvalid),
        .i_awready    (awready),
        .o_wdata      (wdata),
        .o_wstrb      (wstrb),
        .o_wlast      (wlast),
        .o_wvalid     (wvalid),
        .i_wready     (wready),
        .i_bid        (bid),
        .i_bvalid     (bvalid),
        .o_bready     (bready),
        .o_wr_done    (wr_done),
        .o_wr_done_id (wr_done_id)
    );

    // A new read is only taken while AR is empty, so the fields never change mid-handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arid     <= '0;
            r_arlen    <= '0;
            r_rd_outst <= '0;
        end else begin
            if (w_rd_accept) begin
                r_araddr  <= cmd_addr;
                r_arid    <= cmd_id;
                r_arlen   <= cmd_len;
                r_arvalid <= 1'b1;
            end else if (arready) begin
                r_arvalid <= 1'b0;
            end
            case ({w_rd_accept, w_rd_done})
                2'b10:   r_rd_outst <= r_rd_outst + 8'd1;
                2'b01:   r_rd_outst <= r_rd_outst - 8'd1;
                default: r_rd_outst <= r_rd_outst;
            endcase
        end
    end

    assign w_b_err   = bvalid && bready && (bresp != c_RESP_OKAY);
    assign w_r_err   = rvalid && usr_rready && (rresp != c_RESP_OKAY);
    assign w_err_sum = {1'b0, r_err_cnt} + {16'd0, w_b_err} + {16'd0, w_r_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign err_cnt    = r_err_cnt;

    assign usr_rdata  = rdata;
    assign usr_rid    = rid;
    assign usr_rlast  = rlast;
    assign usr_rvalid = rvalid;
    assign rready     = usr_rready;

    assign awsize     = c_AXSIZE;
    assign awburst    = c_BURST_INCR;
    assign awcache    = c_CACHE;
    assign awlock     = 1'b0;
    assign awprot     = 3'b000;
    assign awqos      = 4'd0;
    assign awregion   = 4'd0;

    assign araddr     = r_araddr;
    assign arid       = r_arid;
    assign arlen      = r_arlen;
    assign arvalid    = r_arvalid;
    assign arsize     = c_AXSIZE;
    assign arburst    = c_BURST_INCR;
    assign arcache    = c_CACHE;
    assign arlock     = 1'b0;
    assign arprot     = 3'b000;
    assign arqos      = 4'd0;
    assign arregion   = 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_axi_master_bfm.sv
// ============================================================================
// Module      : tb_axi_master_bfm
// Description : Scoreboard bench for axi_master_bfm with a scripted AXI slave and user-side drivers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_master_bfm;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MW = 64;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [IW-1:0] cmd_id;
    logic [DW-1:0] usr_wdata;
    logic [MW-1:0] usr_wstrb;
    logic          usr_wvalid, usr_wready;
    logic [DW-1:0] usr_rdata;
    logic [IW-1:0] usr_rid;
    logic          usr_rlast, usr_rvalid, usr_rready;
    logic          wr_done;
    logic [IW-1:0] wr_done_id;
    logic [15:0]   err_cnt;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, arid;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize, awprot, arprot;
    logic [1:0]    awburst, arburst;
    logic [3:0]    awcache, arcache, awqos, arqos, awregion, arregion;
    logic          awlock, arlock;
    logic          awvalid, awready, arvalid, arready;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;

    axi_master_bfm dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
        .usr_rdata(usr_rdata), .usr_rid(usr_rid), .usr_rlast(usr_rlast),
        .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
        .wr_done(wr_done), .wr_done_id(wr_done_id), .err_cnt(err_cnt),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awcache(awcache), .awlock(awlock), .awprot(awprot), .awqos(awqos), .awregion(awregion),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arcache(arcache), .arlock(arlock), .arprot(arprot), .arqos(arqos), .arregion(arregion),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [7:0]    len;
    } cmd_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [MW-1:0] s;
        logic          l;
    } wbeat_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        logic          l;
    } rbeat_t;

    cmd_t          exp_aw[$];
    cmd_t          exp_ar[$];
    wbeat_t        exp_w[$];
    wbeat_t        src_w[$];
    logic [IW-1:0] exp_b[$];
    rbeat_t        exp_r[$];
    logic [IW-1:0] slv_bid_q[$];

    int  n_chk  = 0;
    int  n_pass = 0;
    int  n_aw   = 0;
    int  n_w    = 0;
    int  n_done = 0;
    int  n_ar   = 0;
    bit  aw_seen = 1'b0;
    bit  r_flood = 1'b0;
    int  exp_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Channel monitor: every handshake is compared against the scoreboard queues.
    always @(negedge clk) begin
        cmd_t   c;
        wbeat_t wb;
        rbeat_t rb;
        if (rst) begin
            aw_seen = 1'b0;
        end else begin
            if (wvalid) check("w_after_aw", aw_seen, 1);
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                else begin
                    c = exp_aw.pop_front();
                    check("awaddr", awaddr, c.addr);
                    check("awid", awid, c.id);
                    check("awlen", awlen, c.len);
                    check("awsize", awsize, 6);
                end
                slv_bid_q.push_back(awid);
                aw_seen = 1'b1;
                n_aw++;
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                else begin
                    wb = exp_w.pop_front();
                    check("wdata", wdata, wb.d);
                    check("wstrb", wstrb, wb.s);
                    check("wlast", wlast, wb.l);
                end
                if (wlast) aw_seen = 1'b0;
                n_w++;
            end
            if (wr_done) begin
                if (exp_b.size() == 0) check("wr_done_unexpected", 1, 0);
                else check("wr_done_id", wr_done_id, exp_b.pop_front());
                n_done++;
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    c = exp_ar.pop_front();
                    check("araddr", araddr, c.addr);
                    check("arid", arid, c.id);
                    check("arlen", arlen, c.len);
                end
                n_ar++;
            end
            if (usr_rvalid && usr_rready && !r_flood) begin
                if (exp_r.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    rb = exp_r.pop_front();
                    check("usr_rdata", usr_rdata, rb.d);
                    check("usr_rid", usr_rid, rb.id);
                    check("usr_rlast", usr_rlast, rb.l);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input bit rnw, input logic [AW-1:0] a, input logic [7:0] l,
                             input logic [IW-1:0] id, input int budget, output bit acc);
        cmd_t c;
        c = '{addr: a, id: id, len: l};
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_len = l; cmd_id = id;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = 1'b1;
                if (rnw) exp_ar.push_back(c);
                else begin
                    exp_aw.push_back(c);
                    exp_b.push_back(id);
                end
            end
            step();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic prep_wdata(input int len);
        wbeat_t b;
        src_w.delete();
        for (int k = 0; k <= len; k++) begin
            for (int j = 0; j < DW / 32; j++) b.d[j*32 +: 32] = $urandom;
            b.s = {$urandom, $urandom};
            b.l = (k == len);
            src_w.push_back(b);
            exp_w.push_back(b);
        end
    endtask

    task automatic usr_drive(input int n, input bit thr);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 5000) begin
            usr_wvalid = thr ? ($urandom_range(0, 1) == 1) : 1'b1;
            usr_wdata  = src_w[idx].d;
            usr_wstrb  = src_w[idx].s;
            @(negedge clk);
            if (usr_wvalid && usr_wready) idx++;
            step();
            guard++;
        end
        usr_wvalid = 1'b0;
        if (idx < n) check("usr_drive_timeout", idx, n);
    endtask

    task automatic slave_wr(input bit thr, input logic [1:0] resp, input bit do_b);
        bit done;
        int guard;
        done = 0; guard = 0;
        while (!done && guard < 5000) begin
            awready = thr ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (awvalid && awready) done = 1;
            step();
            guard++;
        end
        awready = 1'b0;
        if (!done) check("aw_timeout", 0, 1);
        done = 0; guard = 0;
        while (!done && guard < 5000) begin
            wready = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (wvalid && wready && wlast) done = 1;
            step();
            guard++;
        end
        wready = 1'b0;
        if (!done) check("wlast_timeout", 0, 1);
        if (do_b) begin
            bvalid = 1'b1;
            bresp  = resp;
            bid    = (slv_bid_q.size() != 0) ? slv_bid_q.pop_front() : '0;
            done = 0; guard = 0;
            while (!done && guard < 200) begin
                @(negedge clk);
                if (bvalid && bready) done = 1;
                step();
                guard++;
            end
            bvalid = 1'b0;
            bresp  = 2'b00;
            if (!done) check("bready_timeout", 0, 1);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] l, input logic [IW-1:0] id,
                            input bit thr);
        bit acc;
        int w0, d0;
        w0 = n_w; d0 = n_done;
        prep_wdata(int'(l));
        fork
            issue_cmd(1'b0, a, l, id, 200, acc);
            usr_drive(int'(l) + 1, thr);
            slave_wr(thr, 2'b00, 1'b1);
        join
        step();
        step();
        check("wr_accept", acc, 1);
        check("wr_beats", n_w - w0, int'(l) + 1);
        check("wr_done_cnt", n_done - d0, 1);
    endtask

    task automatic slave_r(input logic [IW-1:0] id, input logic last, input logic [1:0] resp);
        rbeat_t rb;
        bit done;
        for (int j = 0; j < DW / 32; j++) rb.d[j*32 +: 32] = $urandom;
        rb.id = id; rb.l = last;
        exp_r.push_back(rb);
        rdata = rb.d; rid = id; rlast = last; rresp = resp; rvalid = 1'b1; usr_rready = 1'b1;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rvalid && rready) done = 1;
            step();
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        if (!done) check("r_timeout", 0, 1);
    endtask

    // Puts one read in flight and parks a write in its response phase, then
    // returns an error B and an error R on the same clock edge.
    task automatic err_double(input logic [IW-1:0] rd_id);
        bit acc;
        rbeat_t rb;
        arready = 1'b1;
        issue_cmd(1'b1, 64'h5000, 8'd0, rd_id, 50, acc);
        check("err_rd_accept", acc, 1);
        step();
        step();
        arready = 1'b0;
        prep_wdata(0);
        fork
            issue_cmd(1'b0, 64'h5100, 8'd0, 4'hA, 50, acc);
            usr_drive(1, 1'b0);
            slave_wr(1'b0, 2'b00, 1'b0);
        join
        @(negedge clk);
        check("bready_in_resp", bready, 1);
        step();
        for (int j = 0; j < DW / 32; j++) rb.d[j*32 +: 32] = $urandom;
        rb.id = rd_id; rb.l = 1'b1;
        exp_r.push_back(rb);
        bid = (slv_bid_q.size() != 0) ? slv_bid_q.pop_front() : '0;
        bresp = 2'b10; bvalid = 1'b1;
        rdata = rb.d; rid = rd_id; rlast = 1'b1; rresp = 2'b11; rvalid = 1'b1; usr_rready = 1'b1;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        exp_err = sat16(exp_err + 2);
        @(negedge clk);
        check("err_double", err_cnt, exp_err);
        step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int a0, d0, idx;
        rst = 1'b1;
        cmd_valid = 0; cmd_rnw = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        usr_wdata = '0; usr_wstrb = '0; usr_wvalid = 0; usr_rready = 0;
        awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
        arready = 0; rdata = '0; rid = '0; rresp = '0; rlast = 0; rvalid = 0;
        repeat (3) step();

        // Reset state
        @(negedge clk);
        check("rst_awvalid", awvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_rd_outst", dut.r_rd_outst, 0);
        check("arsize", arsize, 6);
        check("awburst", awburst, 1);
        check("awcache", awcache, 4'b0011);
        check("arcache", arcache, 4'b0011);
        step();
        rst = 1'b0;
        step();

        // Single 4-beat write
        do_write(64'h1000, 8'd3, 4'd5, 1'b0);

        // Single-beat read with a delayed arready
        issue_cmd(1'b1, 64'h2000, 8'd0, 4'd2, 20, acc);
        check("rd_accept", acc, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arvalid_hold", arvalid, 1);
            check("araddr_hold", araddr, 64'h2000);
            step();
        end
        a0 = n_ar;
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("ar_hs", n_ar - a0, 1);
        slave_r(4'd2, 1'b1, 2'b00);
        @(negedge clk);
        check("rd_outst_zero", dut.r_rd_outst, 0);
        step();

        // Nine back-to-back reads against an R channel that stays silent
        arready = 1'b1;
        a0 = n_ar;
        for (int i = 0; i < 9; i++) begin
            issue_cmd(1'b1, 64'h3000 + 64'(i * 64), 8'd1, 4'(i), 20, acc);
            check("rd_outst_acc", acc, (i < 8) ? 1 : 0);
        end
        step();
        check("rd_ar_count8", n_ar - a0, 8);
        slave_r(4'd0, 1'b0, 2'b00);
        slave_r(4'd0, 1'b1, 2'b00);
        issue_cmd(1'b1, 64'h3200, 8'd0, 4'd8, 20, acc);
        check("rd_ninth_acc", acc, 1);
        step();
        check("rd_ar_count9", n_ar - a0, 9);
        for (int i = 1; i < 8; i++) begin
            slave_r(4'(i), 1'b0, 2'b00);
            slave_r(4'(i), 1'b1, 2'b00);
        end
        slave_r(4'd8, 1'b1, 2'b00);
        arready = 1'b0;
        @(negedge clk);
        check("rd_outst_drain", dut.r_rd_outst, 0);
        step();

        // Fully throttled 256-beat write
        do_write(64'h4000, 8'd255, 4'd9, 1'b1);

        // Error counting: same-cycle B and R errors, then saturation
        err_double(4'd3);
        r_flood = 1'b1;
        rvalid = 1'b1; rresp = 2'b11; rlast = 1'b0; usr_rready = 1'b1;
        repeat (65531) step();
        exp_err = sat16(exp_err + 65531);
        @(negedge clk);
        check("err_near_sat", err_cnt, exp_err);
        repeat (4) step();
        exp_err = sat16(exp_err + 4);
        rvalid = 1'b0; rresp = 2'b00;
        @(negedge clk);
        check("err_saturated", err_cnt, exp_err);
        step();
        r_flood = 1'b0;
        err_double(4'd4);

        // Reset in the middle of a write burst
        d0 = n_done;
        prep_wdata(3);
        issue_cmd(1'b0, 64'h6000, 8'd3, 4'd7, 20, acc);
        check("rst_wr_accept", acc, 1);
        awready = 1'b1;
        for (int i = 0; i < 20 && aw_seen == 1'b0; i++) step();
        awready = 1'b0;
        wready = 1'b1;
        usr_wvalid = 1'b1;
        idx = 0;
        for (int g = 0; g < 50 && idx < 2; g++) begin
            usr_wdata = src_w[idx].d;
            usr_wstrb = src_w[idx].s;
            @(negedge clk);
            if (wvalid && wready) idx++;
            step();
        end
        check("rst_two_beats", idx, 2);
        rst = 1'b1;
        usr_wvalid = 1'b0;
        wready = 1'b0;
        step();
        rst = 1'b0;
        exp_w.delete();
        exp_b.delete();
        exp_aw.delete();
        slv_bid_q.delete();
        @(negedge clk);
        check("rst_mid_awvalid", awvalid, 0);
        check("rst_mid_wvalid", wvalid, 0);
        check("rst_mid_bready", bready, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        step();
        exp_err = 0;
        check("rst_mid_err_cnt", err_cnt, exp_err);
        repeat (3) step();
        check("rst_no_wr_done", n_done - d0, 0);
        do_write(64'h7000, 8'd0, 4'd8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
